// File: rtl/rot_shift_engine.sv
// Shift/rotate register with manual single-step shifts, counted auto-shift
// bursts, a modulo shift counter and a registered serial output.
module rot_shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             ena,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             start_go;
    logic             step;
    logic             real_shift;
    logic             last_step;
    logic [WIDTH-1:0] shifted;
    logic             exit_bit;

    // Priority: load > start (IDLE) > burst step (BURST) > ena (IDLE)
    always_comb begin
        start_go   = !load && (state == IDLE) && start;
        step       = !load && ((state == BURST) || ((state == IDLE) && !start && ena));
        real_shift = step && (mode != 2'b11);
        last_step  = (remaining == CNT_W'(1));
    end

    always_comb begin
        shifted  = q;
        exit_bit = dir ? q[0] : q[WIDTH-1];
        case (mode)
            2'b00:   shifted = dir ? {q[0], q[WIDTH-1:1]}       : {q[WIDTH-2:0], q[WIDTH-1]};
            2'b01:   shifted = dir ? {sin, q[WIDTH-1:1]}        : {q[WIDTH-2:0], sin};
            2'b10:   shifted = dir ? {q[WIDTH-1], q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
            default: shifted = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && (len != '0)) state_nxt = BURST;
                BURST:   if (last_step)            state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == BURST);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q         <= '0;
            sout      <= 1'b0;
            count     <= '0;
            remaining <= '0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                q         <= data;
                count     <= '0;
                remaining <= '0;
            end else begin
                if (start_go) begin
                    if (len != '0) remaining <= len;
                    else           done      <= 1'b1;
                end
                // Hold mode still consumes a burst step, so remaining is
                // decremented independently of whether q actually moves.
                if (state == BURST) begin
                    remaining <= remaining - 1'b1;
                    if (last_step) done <= 1'b1;
                end
                if (real_shift) begin
                    q     <= shifted;
                    sout  <= exit_bit;
                    count <= count + 1'b1;
                    wrap  <= (count == '1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rot_shift_engine.sv
// Directed bench for rot_shift_engine: stimulus pushes hand-computed expected
// outputs tagged with a cycle number; a monitor pops and compares them.
module tb_rot_shift_engine;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       dir = 1'b0;
    logic [1:0] mode = '0;
    logic       sin = 1'b0;
    logic [7:0] data = '0;
    logic [7:0] q;
    logic       sout;
    logic [3:0] count;
    logic       wrap;
    logic       busy;
    logic       done;

    rot_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .load(load), .ena(ena), .start(start),
        .len(len), .dir(dir), .mode(mode), .sin(sin), .data(data),
        .q(q), .sout(sout), .count(count), .wrap(wrap), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         at;
        logic [7:0] q;
        logic       sout;
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [7:0] eq, input logic es,
                              input logic [3:0] ec, input logic eb, input logic ed,
                              input logic ew);
        exp_t e;
        e.name = name; e.at = cyc; e.q = eq; e.sout = es; e.count = ec;
        e.busy = eb; e.done = ed; e.wrap = ew;
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT outputs against every expectation due this cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (e.at < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         e.name, e.at, cyc);
            end else if (q !== e.q || sout !== e.sout || count !== e.count ||
                         busy !== e.busy || done !== e.done || wrap !== e.wrap) begin
                n_bad++;
                $display("FAIL %s: got q=%h sout=%b count=%0d busy=%b done=%b wrap=%b, want q=%h sout=%b count=%0d busy=%b done=%b wrap=%b",
                         e.name, q, sout, count, busy, done, wrap,
                         e.q, e.sout, e.count, e.busy, e.done, e.wrap);
            end
        end
    end

    initial begin
        logic [15:0] rot;
        int          guard;

        tick();
        expect_now("reset", 8'h00, 0, 0, 0, 0, 0);
        resetn = 1'b1;

        // Rotate left of A5
        load = 1; data = 8'hA5; tick();
        expect_now("load_a5", 8'hA5, 0, 0, 0, 0, 0);
        load = 0; ena = 1; dir = 0; mode = 2'b00; tick();
        expect_now("rotl_a5", 8'h4B, 1, 1, 0, 0, 0);
        ena = 0;

        // Arithmetic right of 81, three steps
        load = 1; data = 8'h81; tick();
        expect_now("load_81", 8'h81, 1, 0, 0, 0, 0);
        load = 0; ena = 1; mode = 2'b10; dir = 1; tick();
        expect_now("asr_1", 8'hC0, 1, 1, 0, 0, 0);
        tick();
        expect_now("asr_2", 8'hE0, 0, 2, 0, 0, 0);
        tick();
        expect_now("asr_3", 8'hF0, 0, 3, 0, 0, 0);

        // Logical both ways, arithmetic left, hold mode, idle hold
        mode = 2'b01; dir = 0; sin = 1; tick();
        expect_now("lsl_sin1", 8'hE1, 1, 4, 0, 0, 0);
        dir = 1; sin = 0; tick();
        expect_now("lsr_sin0", 8'h70, 1, 5, 0, 0, 0);
        mode = 2'b10; dir = 0; tick();
        expect_now("asl", 8'hE0, 0, 6, 0, 0, 0);
        mode = 2'b11; tick();
        expect_now("hold_mode", 8'hE0, 0, 6, 0, 0, 0);
        ena = 0; mode = 2'b00; tick();
        expect_now("idle_hold", 8'hE0, 0, 6, 0, 0, 0);

        // Burst of 8 rotations; start/ena during the burst must be ignored
        load = 1; data = 8'h01; tick();
        expect_now("load_01", 8'h01, 0, 0, 0, 0, 0);
        load = 0; start = 1; len = 4'd8; dir = 0; mode = 2'b00; tick();
        expect_now("burst_start", 8'h01, 0, 0, 1, 0, 0);
        len = 4'd3; ena = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            rot = 16'h0101 << k;
            expect_now($sformatf("burst8_step%0d", k), rot[15:8], (k == 8), 4'(k),
                       (k < 8), (k == 8), 0);
        end
        start = 0; ena = 0; tick();
        expect_now("burst8_after", 8'h01, 1, 8, 0, 0, 0);

        // Counter wrap
        load = 1; data = 8'h00; tick();
        expect_now("load_00", 8'h00, 1, 0, 0, 0, 0);
        load = 0; ena = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 15) expect_now("count_15", 8'h00, 0, 15, 0, 0, 0);
        end
        tick();
        expect_now("wrap_pulse", 8'h00, 0, 0, 0, 0, 1);
        ena = 0; tick();
        expect_now("wrap_clear", 8'h00, 0, 0, 0, 0, 0);

        // Load aborts a burst on its third step
        load = 1; data = 8'h11; tick();
        expect_now("load_11", 8'h11, 0, 0, 0, 0, 0);
        load = 0; start = 1; len = 4'd5; tick();
        expect_now("b5_start", 8'h11, 0, 0, 1, 0, 0);
        start = 0; tick();
        expect_now("b5_step1", 8'h22, 0, 1, 1, 0, 0);
        tick();
        expect_now("b5_step2", 8'h44, 0, 2, 1, 0, 0);
        load = 1; data = 8'h3C; tick();
        expect_now("b5_abort", 8'h3C, 0, 0, 0, 0, 0);
        load = 0; tick();
        expect_now("b5_no_done1", 8'h3C, 0, 0, 0, 0, 0);
        tick();
        expect_now("b5_no_done2", 8'h3C, 0, 0, 0, 0, 0);

        // Reset mid-burst overrides load/ena
        start = 1; len = 4'd4; tick();
        expect_now("b4_start", 8'h3C, 0, 0, 1, 0, 0);
        start = 0; tick();
        expect_now("b4_step1", 8'h78, 0, 1, 1, 0, 0);
        resetn = 0; load = 1; ena = 1; data = 8'hFF; tick();
        expect_now("reset_mid_burst", 8'h00, 0, 0, 0, 0, 0);
        resetn = 1; load = 0; ena = 0; tick();
        expect_now("post_reset_idle", 8'h00, 0, 0, 0, 0, 0);

        // Zero-length start: done pulse, no shift even with ena high
        load = 1; data = 8'hAB; tick();
        expect_now("load_ab", 8'hAB, 0, 0, 0, 0, 0);
        load = 0; start = 1; len = 4'd0; ena = 1; tick();
        expect_now("len0_done", 8'hAB, 0, 0, 0, 1, 0);
        start = 0; ena = 0; tick();
        expect_now("len0_after", 8'hAB, 0, 0, 0, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
